button_conditioner: RTL

- Front-end input stage that sits directly upstream of the game top level.
- Takes raw, asynchronous, bouncing push-button inputs (start plus eight pattern buttons) and synchronizes and debounces each one.
- Produces clean levels, one-cycle press/release pulses, and a validated single-press event with its binary button code.
- Replaces the priority encoder's dependence on raw levels: a chord or held button never yields a valid press.

---
 rtl/button_conditioner.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// Module      : button_conditioner
// Description : Synchronizes and debounces raw push buttons, emits edge pulses
//               and a validated single-press event with its button code.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
   parameter int  NUM_BUTTONS     = 9,
   parameter int  DEBOUNCE_CYCLES = 1000,
   parameter int  SYNC_STAGES     = 2,
   localparam int CODE_W          = $clog2(NUM_BUTTONS),
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   input  logic                   en,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_press,
   output logic [NUM_BUTTONS-1:0] btn_release,
   output logic                   press_valid,
   output logic [CODE_W-1:0]      press_code,
   output logic                   chord_error
);

   localparam logic [CNT_W-1:0]       c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BUTTONS-1:0] c_one     = NUM_BUTTONS'(1);

   logic [NUM_BUTTONS-1:0] r_sync [SYNC_STAGES];
   logic [CNT_W-1:0]       r_cnt  [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] r_stable;
   logic [NUM_BUTTONS-1:0] r_press;
   logic [NUM_BUTTONS-1:0] r_release;
   logic                   r_press_valid;
   logic [CODE_W-1:0]      r_press_code;
   logic                   r_chord_error;

   logic [NUM_BUTTONS-1:0] w_sync;
   logic [NUM_BUTTONS-1:0] w_held;
   logic                   w_one_hot;
   logic [CODE_W-1:0]      w_code;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= btn_raw;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Any cycle where the synchronized input agrees with the accepted level
   // restarts that bit's count, so bounces never accumulate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stable  <= '0;
         r_press   <= '0;
         r_release <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            r_press[i]   <= 1'b0;
            r_release[i] <= 1'b0;
            if (w_sync[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == c_cnt_max) begin
               r_stable[i]  <= w_sync[i];
               r_cnt[i]     <= '0;
               r_press[i]   <= w_sync[i];
               r_release[i] <= ~w_sync[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_held    = r_stable & ~r_press;
   assign w_one_hot = ((r_press & (r_press - c_one)) == '0);

   always_comb begin
      w_code = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (r_press[i]) w_code = CODE_W'(i);
      end
   end

   // Only a lone new press with nothing else held is accepted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_press_valid <= 1'b0;
         r_press_code  <= '0;
         r_chord_error <= 1'b0;
      end else if (en && (r_press != '0)) begin
         if (w_one_hot && (w_held == '0)) begin
            r_press_valid <= 1'b1;
            r_press_code  <= w_code;
            r_chord_error <= 1'b0;
         end else begin
            r_press_valid <= 1'b0;
            r_chord_error <= 1'b1;
         end
      end else begin
         r_press_valid <= 1'b0;
         r_chord_error <= 1'b0;
      end
   end

   assign btn_level   = r_stable;
   assign btn_press   = r_press;
   assign btn_release = r_release;
   assign press_valid = r_press_valid;
   assign press_code  = r_press_code;
   assign chord_error = r_chord_error;

endmodule

`default_nettype wire
